// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a host byte stream into
// instruction memory, holding the core stalled until the last write lands.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65535,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_FLUSH, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_FLUSH, S_DONE, S_ERR} state_t;
`endif

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic        accept;
  logic [15:0] len_in;
  logic        word_done;
  logic        last_word;
  state_t      tail_state;

  logic              in_ready_d, mem_we_d, core_hold_d, done_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  assign accept    = in_valid && in_ready;
  assign len_in    = {in_data, len_lo};
  assign word_done = accept && (state == S_DATA) && (byte_idx == 2'd3);
  assign last_word = (words_loaded + 16'd1) == n_words;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;
  assign tail_state = S_CSUM;
`else
  assign tail_state = S_FLUSH;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LEN0;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0:  if (accept) state_nxt = S_LEN1;
      S_LEN1:  if (accept) begin
        if (32'(len_in) > 32'(DEPTH)) state_nxt = S_ERR;
        else if (len_in == 16'd0)     state_nxt = tail_state;
        else                          state_nxt = S_DATA;
      end
      S_DATA:  if (word_done && last_word) state_nxt = tail_state;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:  if (accept) state_nxt = (in_data == csum) ? S_FLUSH : S_ERR;
`endif
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_LEN0;
    endcase
  end

  // registered outputs follow the state being entered, so they line up with it
  always_comb begin
    in_ready_d  = (state_nxt != S_FLUSH) && (state_nxt != S_DONE);
    core_hold_d = (state_nxt != S_DONE);
    done_d      = (state_nxt == S_DONE);
    err_d       = (state_nxt == S_ERR);
    mem_we_d    = word_done;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (word_done) begin
      mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(words_loaded);
      mem_wdata_d = {in_data, asm_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      core_hold <= core_hold_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // datapath: length capture, byte assembly, word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo       <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      words_loaded <= '0;
    end else if (accept) begin
      case (state)
        S_LEN0: len_lo  <= in_data;
        S_LEN1: n_words <= len_in;
        S_DATA: begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    asm_q[7:0]   <= in_data;
            2'd1:    asm_q[15:8]  <= in_data;
            2'd2:    asm_q[23:16] <= in_data;
            default: words_loaded <= words_loaded + 16'd1;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // running XOR over header and data bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum <= '0;
    else if (accept && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
      csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the basic stream plus
// hand-written sequences for bubbles, zero length, oversize, checksum, reset.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, core_hold, done, err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader #(.ADDR_W(16), .DEPTH(4), .BASE_ADDR(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // write capture and back-to-back mem_we detection
  logic [47:0] wr_q[$];
  int          we_dbl = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_we && prev_we) we_dbl++;
    prev_we = mem_we;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        hold, done, err, rdy;
    logic [15:0] wl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic we,
                     input logic [15:0] addr, input logic [31:0] wdata,
                     input logic hold, input logic dn, input logic er,
                     input logic rdy, input logic [15:0] wl);
    vec_t r;
    r.v = v; r.d = d; r.we = we; r.addr = addr; r.wdata = wdata;
    r.hold = hold; r.done = dn; r.err = er; r.rdy = rdy; r.wl = wl;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 1);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_hold", 32'(core_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_words", 32'(words_loaded), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    apply_reset();

    // basic 2-word stream, checked every cycle
    add(1, 8'h02, 0, 1, 32'h0, 1, 0, 0, 1, 0);
    add(1, 8'h00, 0, 1, 32'h0, 1, 0, 0, 1, 0);
    add(1, 8'h78, 0, 1, 32'h0, 1, 0, 0, 1, 0);
    add(1, 8'h56, 0, 1, 32'h0, 1, 0, 0, 1, 0);
    add(1, 8'h34, 0, 1, 32'h0, 1, 0, 0, 1, 0);
    add(1, 8'h12, 1, 1, 32'h12345678, 1, 0, 0, 1, 1);
    add(1, 8'hEF, 0, 1, 32'h12345678, 1, 0, 0, 1, 1);
    add(1, 8'hBE, 0, 1, 32'h12345678, 1, 0, 0, 1, 1);
    add(1, 8'hAD, 0, 1, 32'h12345678, 1, 0, 0, 1, 1);
`ifdef IMEM_LOADER_CSUM_EN
    add(1, 8'hDE, 1, 2, 32'hDEADBEEF, 1, 0, 0, 1, 2);
    add(0, 8'h00, 0, 2, 32'hDEADBEEF, 1, 0, 0, 1, 2);
    add(1, 8'h28, 0, 2, 32'hDEADBEEF, 1, 0, 0, 0, 2);
    add(0, 8'h00, 0, 2, 32'hDEADBEEF, 0, 1, 0, 0, 2);
`else
    add(1, 8'hDE, 1, 2, 32'hDEADBEEF, 1, 0, 0, 0, 2);
    add(0, 8'h00, 0, 2, 32'hDEADBEEF, 0, 1, 0, 0, 2);
`endif
    add(0, 8'h00, 0, 2, 32'hDEADBEEF, 0, 1, 0, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_hold", i), 32'(core_hold), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wl", i), 32'(words_loaded), 32'(tbl[i].wl));
    end
    in_valid = 1'b0;

    // same stream with 3 idle cycles between bytes
    apply_reset();
    begin
      logic [7:0] s [10];
      s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 10; i++) send_byte(s[i], 3);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h28, 3);
`endif
    repeat (3) tick();
    chk("bub_nwrites", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("bub_w0", wr_q[0][31:0], 32'h12345678);
      chk("bub_a0", 32'(wr_q[0][47:32]), 1);
      chk("bub_w1", wr_q[1][31:0], 32'hDEADBEEF);
      chk("bub_a1", 32'(wr_q[1][47:32]), 2);
    end
    chk("bub_done", 32'(done), 1);
    chk("bub_hold", 32'(core_hold), 0);
    chk("bub_wl", 32'(words_loaded), 2);

    // zero length
    apply_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00, 0);
`endif
    tick();
    chk("zero_done", 32'(done), 1);
    chk("zero_hold", 32'(core_hold), 0);
    chk("zero_nwrites", wr_q.size(), 0);

    // oversize header with DEPTH=4, then bytes must keep draining
    apply_reset();
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    chk("ovr_err", 32'(err), 1);
    chk("ovr_hold", 32'(core_hold), 1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("ovr_rdy%0d", i), 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = 8'(i * 13 + 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("ovr_nwrites", wr_q.size(), 0);
    chk("ovr_err_sticky", 32'(err), 1);
    chk("ovr_done", 32'(done), 0);

`ifdef IMEM_LOADER_CSUM_EN
    // checksum good
    apply_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    tick();
    chk("csok_done", 32'(done), 1);
    chk("csok_err", 32'(err), 0);
    // checksum bad
    apply_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h46, 0);
    tick();
    chk("csbad_err", 32'(err), 1);
    chk("csbad_hold", 32'(core_hold), 1);
    chk("csbad_done", 32'(done), 0);
    chk("csbad_nwrites", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      chk("csbad_a0", 32'(wr_q[0][47:32]), 1);
      chk("csbad_w0", wr_q[0][31:0], 32'h44332211);
    end
`endif

    // reset after 6 bytes of a 2-word load, then a fresh 1-word load
    apply_reset();
    begin
      logic [7:0] s [6];
      s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    end
    chk("mid_we_before", 32'(mem_we), 1);
    apply_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h01, 0);
`endif
    repeat (2) tick();
    chk("mid_nwrites", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      chk("mid_a0", 32'(wr_q[0][47:32]), 1);
      chk("mid_w0", wr_q[0][31:0], 32'hDDCCBBAA);
    end
    chk("mid_done", 32'(done), 1);
    chk("mid_wl", 32'(words_loaded), 1);

    chk("we_single_cycle", we_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
